// File: rtl/mc_decoder_if.sv
// Instruction-field inputs and per-cycle control outputs of the multicycle decoder.
// The slave side is the decoder; the master side drives the IR fields.
interface mc_decoder_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       InstrDone;
    logic       Illegal;

    modport slave (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               ImmSrc, RegSrc, FlagW, PCS, RegW, MemW, Branch, InstrDone, Illegal
    );

    modport master (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
               ImmSrc, RegSrc, FlagW, PCS, RegW, MemW, Branch, InstrDone, Illegal
    );
endinterface

// File: rtl/mc_decoder.sv
// Multicycle ARM-subset control decoder: Moore main FSM, ALU decoder and
// source-select decode. Write/branch requests are produced before CondEx gating.
module mc_decoder (
    input  logic         clk,
    input  logic         reset,
    mc_decoder_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    localparam logic [3:0] CMD_CMP = 4'b1010;

    state_t     state, state_nxt;
    logic       irw, npc, regw, memw, br, done, ill;
    logic       adr_src, src_a, alu_op;
    logic [1:0] src_b, res_src;
    logic [1:0] alu_ctl, flag_w;
    logic [3:0] cmd;

    assign cmd = bus.Funct[4:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        irw       = 1'b0;
        npc       = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        br        = 1'b0;
        done      = 1'b0;
        ill       = 1'b0;
        adr_src   = 1'b0;
        src_a     = 1'b0;
        src_b     = 2'b00;
        res_src   = 2'b00;
        alu_op    = 1'b0;
        case (state)
            FETCH: begin
                irw       = 1'b1;
                npc       = 1'b1;
                src_a     = 1'b1;
                src_b     = 2'b10;
                res_src   = 2'b10;
                state_nxt = DECODE;
            end
            DECODE: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
                case (bus.Op)
                    2'b00:   state_nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = UNKNOWN;
                endcase
            end
            MEMADR: begin
                src_b     = 2'b01;
                state_nxt = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src   = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                res_src = 2'b01;
                regw    = 1'b1;
                done    = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                memw    = 1'b1;
                done    = 1'b1;
            end
            EXECUTER: begin
                alu_op    = 1'b1;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                src_b     = 2'b01;
                alu_op    = 1'b1;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                regw = (cmd != CMD_CMP);
                done = 1'b1;
            end
            BRANCH: begin
                src_b   = 2'b01;
                res_src = 2'b10;
                br      = 1'b1;
                done    = 1'b1;
            end
            UNKNOWN: begin
                ill  = 1'b1;
                done = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // ALU decode only acts in the execute cycle, so flags update once per instruction
    always_comb begin
        alu_ctl = 2'b00;
        flag_w  = 2'b00;
        if (alu_op) begin
            case (cmd)
                4'b0100: alu_ctl = 2'b00;
                4'b0010: alu_ctl = 2'b01;
                CMD_CMP: alu_ctl = 2'b01;
                4'b0000: alu_ctl = 2'b10;
                4'b1100: alu_ctl = 2'b11;
                default: alu_ctl = 2'b00;
            endcase
            flag_w[1] = bus.Funct[0];
            flag_w[0] = bus.Funct[0] & ~alu_ctl[1];
            if (cmd == CMD_CMP) flag_w = 2'b11;
        end
    end

    // Strobes are held low while reset is asserted; the state is already FETCH then
    assign bus.IRWrite    = reset & irw;
    assign bus.NextPC     = reset & npc;
    assign bus.RegW       = reset & regw;
    assign bus.MemW       = reset & memw;
    assign bus.Branch     = reset & br;
    assign bus.InstrDone  = reset & done;
    assign bus.Illegal    = reset & ill;
    assign bus.PCS        = bus.Branch | (bus.RegW & (bus.Rd == 4'd15));

    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUControl = alu_ctl;
    assign bus.FlagW      = flag_w;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
endmodule
